// File: rtl/fmt_pkg.sv
// Shared types and constants for the ALU result text formatter.
package fmt_pkg;

  localparam int RESULT_W   = 16;
  localparam int BCD_DIGITS = 5;

  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_MINUS = 8'h2D;
  localparam logic [7:0] CH_ZERO  = 8'h30;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FORMAT
  } state_t;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble correction: a BCD nibble of 5 or more gets 3 added before the shift.
module bcd_add3 (
  input  logic [3:0] nib_in,
  output logic [3:0] nib_out
);

  assign nib_out = (nib_in >= 4'd5) ? nib_in + 4'd3 : nib_in;

endmodule

// File: rtl/alu_result_formatter.sv
// Turns a 16-bit ALU result into a 6-character ASCII field (sign + 5 digits)
// using a 16-step shift-and-add-3 conversion, then pulses done.
module alu_result_formatter
  import fmt_pkg::*;
#(
  parameter int WIDTH  = RESULT_W,
  parameter int DIGITS = BCD_DIGITS
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [WIDTH-1:0]          value,
  input  logic                      signed_mode,
  output logic                      busy,
  output logic                      done,
  output logic [8*(DIGITS+1)-1:0]   text
);

  state_t                  state;
  logic [WIDTH-1:0]        bin;
  logic [4*DIGITS-1:0]     bcd;
  logic [4*DIGITS-1:0]     bcd_adj;
  logic [3:0]              cnt;
  logic                    neg;
  logic                    neg_in;
  logic [8*(DIGITS+1)-1:0] text_next;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .nib_in  (bcd[4*g +: 4]),
      .nib_out (bcd_adj[4*g +: 4])
    );
  end

  assign busy   = (state != IDLE);
  assign neg_in = signed_mode & value[WIDTH-1];

  // Blank every digit left of the first nonzero one; the units digit always prints.
  always_comb begin
    logic       lead;
    logic [3:0] nib;
    text_next = '0;
    lead      = 1'b1;
    nib       = 4'h0;
    text_next[8*DIGITS +: 8] = neg ? CH_MINUS : CH_SPACE;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      nib = bcd[4*i +: 4];
      if (lead && nib == 4'h0 && i != 0) begin
        text_next[8*i +: 8] = CH_SPACE;
      end else begin
        lead = 1'b0;
        text_next[8*i +: 8] = CH_ZERO + {4'h0, nib};
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      done  <= 1'b0;
      text  <= {(DIGITS+1){CH_SPACE}};
      cnt   <= '0;
      bin   <= '0;
      bcd   <= '0;
      neg   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            neg   <= neg_in;
            bin   <= neg_in ? (~value + 1'b1) : value;
            bcd   <= '0;
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          bcd <= {bcd_adj[4*DIGITS-2:0], bin[WIDTH-1]};
          bin <= {bin[WIDTH-2:0], 1'b0};
          cnt <= cnt + 4'd1;
          if (cnt == 4'd15) state <= FORMAT;
        end
        FORMAT: begin
          text  <= text_next;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_result_formatter.sv
// Scoreboard bench for alu_result_formatter: stimulus pushes expected text and
// due cycle, an independent monitor checks every done pulse against the queue.
module tb_alu_result_formatter;

  typedef struct {
    logic [47:0] txt;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] value = '0;
  logic        signed_mode = 1'b0;
  logic        busy;
  logic        done;
  logic [47:0] text;

  int   cycle = 0;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb_q[$];

  alu_result_formatter dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .value       (value),
    .signed_mode (signed_mode),
    .busy        (busy),
    .done        (done),
    .text        (text)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cycle);
    end
  endtask

  // Monitor: every done pulse must match the oldest pending expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && done === 1'b1) begin
        if (sb_q.size() == 0) begin
          check("unexpected_done", 48'h1, 48'h0);
        end else begin
          e = sb_q.pop_front();
          check("text", text, e.txt);
          check("latency", 48'(cycle), 48'(e.due));
          check("busy_in_done", {47'h0, busy}, 48'h0);
        end
      end
    end
  end

  // Drive a request at a negedge; the accepting edge follows, done 17 clocks later.
  task automatic issue(input logic [15:0] v, input logic s, input logic [47:0] exp_txt, input bit expect_it);
    exp_t e;
    value       = v;
    signed_mode = s;
    start       = 1'b1;
    if (expect_it) begin
      e.txt = exp_txt;
      e.due = cycle + 18;
      sb_q.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      check("drain_timeout", 48'(sb_q.size()), 48'h0);
      sb_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int n;
    repeat (2) @(negedge clk);
    check("reset_text", text, 48'h2020_2020_2020);
    check("reset_busy", {47'h0, busy}, 48'h0);
    check("reset_done", {47'h0, done}, 48'h0);
    reset = 1'b0;
    @(negedge clk);

    issue(16'd1234, 1'b1, 48'h2020_3132_3334, 1'b1);
    check("busy_after_start", {47'h0, busy}, 48'h1);
    drain();
    issue(16'hFFFF, 1'b1, 48'h2D20_2020_2031, 1'b1); drain();
    issue(16'hFFFF, 1'b0, 48'h2036_3535_3335, 1'b1); drain();
    issue(16'h8000, 1'b1, 48'h2D33_3237_3638, 1'b1); drain();
    issue(16'h8000, 1'b0, 48'h2033_3237_3638, 1'b1); drain();
    issue(16'h0000, 1'b1, 48'h2020_2020_2030, 1'b1); drain();
    issue(16'd7,    1'b0, 48'h2020_2020_2037, 1'b1); drain();
    issue(16'hFF9C, 1'b1, 48'h2D20_2031_3030, 1'b1); drain();
    issue(16'd10000, 1'b0, 48'h2031_3030_3030, 1'b1); drain();

    // Start while busy must be dropped.
    issue(16'd100, 1'b0, 48'h2020_2031_3030, 1'b1);
    repeat (4) @(negedge clk);
    issue(16'd999, 1'b0, 48'h0, 1'b0);
    drain();

    // Back-to-back: re-issue in the done cycle.
    issue(16'd42, 1'b0, 48'h2020_2020_3432, 1'b1);
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (done !== 1'b1) check("b2b_done_timeout", 48'h0, 48'h1);
    issue(16'd65, 1'b1, 48'h2020_2020_3635, 1'b1);
    drain();

    // Reset mid-conversion: no done may follow.
    issue(16'd5555, 1'b0, 48'h0, 1'b0);
    repeat (7) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midreset_busy", {47'h0, busy}, 48'h0);
    check("midreset_text", text, 48'h2020_2020_2020);
    check("midreset_done", {47'h0, done}, 48'h0);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    check("midreset_idle", {47'h0, busy}, 48'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
